// File: rtl/led_arb_pkg.sv
// Shared types, widths and blink-mode helper for the debug LED bank arbiter.
// Optional feature macro used by led_arb_ctrl: LED_ARB_STICKY_ERR_EN.
package led_arb_pkg;

    localparam int unsigned LED_W   = 16;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned OWNER_W = 3;

    typedef enum logic [MODE_W-1:0] {
        SOLID = 2'd0,
        FAST  = 2'd1,
        SLOW  = 2'd2,
        ALT   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Pattern plus display mode as offered by one requester.
    typedef struct packed {
        logic [LED_W-1:0] pattern;
        mode_e            mode;
    } disp_t;

    function automatic logic [LED_W-1:0] apply_mode(
        input logic [LED_W-1:0] pattern,
        input mode_e            mode,
        input logic             fast_ph,
        input logic             slow_ph
    );
        logic [LED_W-1:0] res;
        res = pattern;
        case (mode)
            SOLID: res = pattern;
            FAST:  res = pattern & {LED_W{fast_ph}};
            SLOW:  res = pattern & {LED_W{slow_ph}};
            ALT:   res = fast_ph ? pattern : ~pattern;
            default: res = pattern;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_arb_ctrl_blink.sv
// Shared blink prescaler: fast tick divider, slow phase counter and both phases.
// A restart pulse realigns all phases so a fresh grant always starts lit.
module led_blink_tick #(
    parameter int unsigned TICK_DIV  = 12500000,
    parameter int unsigned SLOW_MULT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick_c,
    output logic fast_ph,
    output logic slow_ph
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SLOW_W = (SLOW_MULT > 1) ? $clog2(SLOW_MULT) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [SLOW_W-1:0] slow_cnt;

    assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt      <= '0;
            slow_cnt <= '0;
            fast_ph  <= 1'b1;
            slow_ph  <= 1'b1;
        end else if (tick_c) begin
            cnt     <= '0;
            fast_ph <= ~fast_ph;
            if (slow_cnt == SLOW_W'(SLOW_MULT - 1)) begin
                slow_cnt <= '0;
                slow_ph  <= ~slow_ph;
            end else begin
                slow_cnt <= slow_cnt + SLOW_W'(1);
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_arb_ctrl.sv
// Fixed-priority arbiter/sequencer sharing the 16-bit debug LED bank with hold time.
// Define LED_ARB_STICKY_ERR_EN to make requester 0 sticky until sticky_clr.
module led_arb_ctrl
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned SLOW_MULT  = 4,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef LED_ARB_STICKY_ERR_EN
    input  logic                     sticky_clr,
`endif
    input  logic [LED_W-1:0]         idle_led,
    input  logic [N_REQ-1:0]         req,
    input  logic [LED_W*N_REQ-1:0]   req_pattern,
    input  logic [MODE_W*N_REQ-1:0]  req_mode,
    output logic [LED_W-1:0]         led,
    output logic [OWNER_W-1:0]       owner,
    output logic                     owner_vld,
    output logic                     grant_chg
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    state_e             state;
    logic [HOLD_W-1:0]  hold_cnt;
    disp_t              samp_disp;

    logic               tick_c;
    logic               fast_ph;
    logic               slow_ph;

    logic [N_REQ-1:0]   req_eff;
    disp_t              disp_in [N_REQ];
    logic               any_req;
    logic [OWNER_W-1:0] win;
    disp_t              win_disp;
    logic               owner_req;
    disp_t              owner_disp;
    disp_t              cur_disp;
    logic               hold_done;
    logic               rearb;
    logic               grant;

`ifdef LED_ARB_STICKY_ERR_EN
    logic  sticky;
    disp_t sticky_disp;

    // Set wins over clear; requester 0's display is frozen at the last capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky      <= 1'b0;
            sticky_disp <= '0;
        end else if (req[0]) begin
            sticky      <= 1'b1;
            sticky_disp <= disp_in_raw0();
        end else if (sticky_clr) begin
            sticky <= 1'b0;
        end
    end

    function automatic disp_t disp_in_raw0();
        disp_t d;
        d.pattern = req_pattern[LED_W-1:0];
        d.mode    = mode_e'(req_mode[MODE_W-1:0]);
        return d;
    endfunction
`endif

    // Effective requests and displays, with the sticky overlay on requester 0.
    always_comb begin
        req_eff = req;
        for (int i = 0; i < N_REQ; i++) begin
            disp_in[i].pattern = req_pattern[LED_W*i +: LED_W];
            disp_in[i].mode    = mode_e'(req_mode[MODE_W*i +: MODE_W]);
        end
`ifdef LED_ARB_STICKY_ERR_EN
        req_eff[0] = req[0] | sticky;
        if (!req[0] && sticky) begin
            disp_in[0] = sticky_disp;
        end
`endif
    end

    // Lowest index wins; also look up the owner's live request and display.
    always_comb begin
        any_req    = |req_eff;
        win        = '0;
        win_disp   = disp_in[0];
        owner_req  = 1'b0;
        owner_disp = disp_in[0];
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_eff[i]) begin
                win      = OWNER_W'(i);
                win_disp = disp_in[i];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == OWNER_W'(i)) begin
                owner_req  = req_eff[i];
                owner_disp = disp_in[i];
            end
        end
    end

    assign cur_disp  = owner_req ? owner_disp : samp_disp;
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_TICKS));
    assign rearb     = (state == SHOW) && hold_done && (!owner_req || (win < owner));
    assign grant     = any_req && (((state == IDLE)) || (rearb && (win != owner)));

    led_blink_tick #(
        .TICK_DIV  (TICK_DIV),
        .SLOW_MULT (SLOW_MULT)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .restart (grant),
        .tick_c  (tick_c),
        .fast_ph (fast_ph),
        .slow_ph (slow_ph)
    );

    // Ownership FSM; a grant restarts phases so the new pattern shows lit at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            led       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            grant_chg <= 1'b0;
            hold_cnt  <= '0;
            samp_disp <= '0;
        end else begin
            grant_chg <= 1'b0;
            if (grant) begin
                state     <= SHOW;
                owner     <= win;
                owner_vld <= 1'b1;
                grant_chg <= 1'b1;
                hold_cnt  <= '0;
                samp_disp <= win_disp;
                led       <= apply_mode(win_disp.pattern, win_disp.mode, 1'b1, 1'b1);
            end else begin
                case (state)
                    IDLE: begin
                        led <= idle_led;
                    end
                    SHOW: begin
                        if (rearb && !any_req) begin
                            state     <= IDLE;
                            owner_vld <= 1'b0;
                            grant_chg <= 1'b1;
                            led       <= idle_led;
                        end else begin
                            led       <= apply_mode(cur_disp.pattern, cur_disp.mode,
                                                    fast_ph, slow_ph);
                            samp_disp <= cur_disp;
                            if (tick_c && !hold_done) begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_arb_ctrl.sv
// Scoreboard bench for led_arb_ctrl: directed scenarios then random traffic
// against a phase-arithmetic reference model.
module tb_led_arb_ctrl;

    localparam int TD = 4;
    localparam int SM = 2;
    localparam int HT = 3;
    localparam int NR = 4;

    logic          clk;
    logic          rst;
    logic          sticky_clr;
    logic [15:0]   idle_led;
    logic [NR-1:0] req;
    logic [16*NR-1:0] req_pattern;
    logic [2*NR-1:0]  req_mode;
    logic [15:0]   led;
    logic [2:0]    owner;
    logic          owner_vld;
    logic          grant_chg;

    led_arb_ctrl #(
        .N_REQ      (NR),
        .TICK_DIV   (TD),
        .SLOW_MULT  (SM),
        .HOLD_TICKS (HT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LED_ARB_STICKY_ERR_EN
        .sticky_clr  (sticky_clr),
`endif
        .idle_led    (idle_led),
        .req         (req),
        .req_pattern (req_pattern),
        .req_mode    (req_mode),
        .led         (led),
        .owner       (owner),
        .owner_vld   (owner_vld),
        .grant_chg   (grant_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        logic [2:0]  owner;
        logic        vld;
        logic        gchg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: m_pc is cycles since the last phase restart.
    bit          m_show;
    int          m_owner;
    int          m_hold;
    logic [15:0] m_pat;
    int          m_mode;
    int          m_pc;
    logic [15:0] m_led;
    bit          m_vld;
    bit          m_gchg;
    bit          m_sticky;
    logic [15:0] m_spat;
    int          m_smode;

    function automatic logic [15:0] ref_mode(logic [15:0] p, int m, bit f, bit s);
        case (m)
            0:       return p;
            1:       return f ? p : 16'h0000;
            2:       return s ? p : 16'h0000;
            default: return f ? p : ~p;
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        e.led  = m_led;
        e.owner = 3'(m_owner);
        e.vld  = m_vld;
        e.gchg = m_gchg;
        q.push_back(e);
    endtask

    task automatic model_step();
        logic [15:0] p [NR];
        int          md [NR];
        bit          r [NR];
        int          win;
        bit          fp, sp, tick, ownreq, do_grant;
        logic [15:0] cp;
        int          cm;
        int          next_pc;
        if (rst) begin
            m_show = 0; m_owner = 0; m_hold = 0; m_pat = '0; m_mode = 0;
            m_pc = 0; m_led = '0; m_vld = 0; m_gchg = 0; m_sticky = 0;
            m_spat = '0; m_smode = 0;
            push_exp();
            return;
        end
        for (int i = 0; i < NR; i++) begin
            p[i]  = req_pattern[16*i +: 16];
            md[i] = int'(req_mode[2*i +: 2]);
            r[i]  = req[i];
        end
`ifdef LED_ARB_STICKY_ERR_EN
        if (!req[0] && m_sticky) begin
            p[0]  = m_spat;
            md[0] = m_smode;
        end
        r[0] = req[0] | m_sticky;
`endif
        win = -1;
        for (int i = NR - 1; i >= 0; i--) if (r[i]) win = i;
        fp      = ((m_pc / TD) % 2) == 0;
        sp      = ((m_pc / (TD * SM)) % 2) == 0;
        tick    = (m_pc % TD) == TD - 1;
        next_pc = (m_pc + 1) % (2 * TD * SM);
        m_gchg   = 0;
        do_grant = 0;
        if (!m_show) begin
            m_led = idle_led;
            if (win >= 0) do_grant = 1;
        end else begin
            ownreq = r[m_owner];
            cp = ownreq ? p[m_owner] : m_pat;
            cm = ownreq ? md[m_owner] : m_mode;
            if (m_hold == HT && (!ownreq || (win >= 0 && win < m_owner))) begin
                if (win >= 0) begin
                    do_grant = 1;
                end else begin
                    m_show = 0; m_vld = 0; m_gchg = 1; m_led = idle_led;
                end
            end else begin
                m_led  = ref_mode(cp, cm, fp, sp);
                m_pat  = cp;
                m_mode = cm;
                if (tick && m_hold < HT) m_hold++;
            end
        end
        if (do_grant) begin
            m_show = 1; m_owner = win; m_vld = 1; m_gchg = 1; m_hold = 0;
            next_pc = 0;
            m_pat  = p[win];
            m_mode = md[win];
            m_led  = ref_mode(p[win], md[win], 1'b1, 1'b1);
        end
        m_pc = next_pc;
        if (req[0]) begin
            m_sticky = 1;
            m_spat   = req_pattern[15:0];
            m_smode  = int'(req_mode[1:0]);
        end else if (sticky_clr) begin
            m_sticky = 0;
        end
        push_exp();
    endtask

    task automatic check16(string name, logic [15:0] act, logic [15:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // Monitor: compares DUT outputs just after each active edge.
    logic [2:0] prev_owner;
    logic       prev_vld;
    initial begin
        exp_t e;
        prev_owner = '0;
        prev_vld   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check16("led", led, e.led);
                check16("owner_vld", 16'(owner_vld), 16'(e.vld));
                check16("grant_chg", 16'(grant_chg), 16'(e.gchg));
                if (e.vld) check16("owner", 16'(owner), 16'(e.owner));
                if (owner_vld && prev_vld && !grant_chg)
                    check16("owner_stable", 16'(owner), 16'(prev_owner));
                prev_owner = owner;
                prev_vld   = owner_vld;
            end
        end
    end

    task automatic cyc(int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_req(int i, bit on, logic [15:0] pat, logic [1:0] md);
        req[i] = on;
        req_pattern[16*i +: 16] = pat;
        req_mode[2*i +: 2] = md;
    endtask

    initial begin
        rst = 1'b1; sticky_clr = 1'b0; idle_led = 16'h0001;
        req = '0; req_pattern = '0; req_mode = '0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        set_req(2, 1, 16'hF00F, 2'd1);
        cyc(7);
        set_req(0, 1, 16'hAAAA, 2'd0);
        cyc(20);
        req = '0;
        sticky_clr = 1'b1;
        cyc(20);
        sticky_clr = 1'b0;
        set_req(1, 1, 16'h00FF, 2'd3);
        cyc(6);
        req[1] = 1'b0;
        cyc(20);
        set_req(3, 1, 16'h00FF, 2'd2);
        cyc(10);
        set_req(1, 1, 16'h1234, 2'd0);
        cyc(20);
        set_req(1, 0, 16'h1234, 2'd0);
        set_req(2, 1, 16'h5A5A, 2'd3);
        cyc(20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = '0;
        cyc(6);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 19) == 0) req_pattern[16*i +: 16] = 16'($urandom);
                if ($urandom_range(0, 19) == 0) req_mode[2*i +: 2] = 2'($urandom);
            end
            if ($urandom_range(0, 49) == 0) idle_led = 16'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            sticky_clr = ($urandom_range(0, 9) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
